// File: rtl/match_window_counter_if.sv
// Bundles the control inputs and status outputs of match_window_counter.
// The master side drives z_in/start/hold/stop and observes the results;
// the slave side is the counter itself. clk and reset stay plain ports.
interface match_window_counter_if #(
  parameter int CNT_W = 8
) ();
  logic             z_in;
  logic             start;
  logic             hold;
  logic             stop;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last_count;
  logic             win_done;
  logic             alarm;
  logic             busy;

  modport master (
    output z_in, start, hold, stop,
    input  count, last_count, win_done, alarm, busy
  );

  modport slave (
    input  z_in, start, hold, stop,
    output count, last_count, win_done, alarm, busy
  );
endinterface

// File: rtl/match_window_counter.sv
// match_window_counter: counts match pulses (z_in) over fixed windows of
// WIN_LEN running cycles. Windows run back to back, can be frozen with hold
// and aborted with stop. Each completed window reports its final count,
// a one-cycle win_done pulse and an alarm flag (count >= THRESH).
// Optional build macro ALARM_STICKY_EN: when defined, the alarm latches
// once set and is cleared only by stop or reset; when undefined, the alarm
// is recomputed at every window end from the new last_count.
module match_window_counter #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  match_window_counter_if.slave    bus
);

  localparam int TMR_W = $clog2(WIN_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_last;
  logic             r_done;
  logic             r_alarm;
  logic             r_busy;

  logic [CNT_W-1:0] w_count_next;
  logic             w_alarm_hit;

  // Saturating match count for the current cycle, and the alarm test on it
  always_comb begin
    w_count_next = r_count;
    if (bus.z_in && (r_count != CNT_MAX)) begin
      w_count_next = r_count + CNT_W'(1);
    end
    w_alarm_hit = (w_count_next >= CNT_THR);
  end

  // Window FSM: stop beats hold, hold beats start and the window logic.
  // RUN and HOLD share the counting step, so a HOLD cycle with hold low
  // resumes counting immediately (including a deferred window end).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state <= S_IDLE;
        r_timer <= '0;
        r_count <= '0;
        r_busy  <= 1'b0;
`ifdef ALARM_STICKY_EN
        r_alarm <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.hold) begin
              r_state <= S_RUN;
              r_timer <= '0;
              r_count <= '0;
              r_busy  <= 1'b1;
            end
          end
          S_RUN, S_HOLD: begin
            if (bus.hold) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_RUN;
              if (r_timer == TMR_LAST) begin
                r_last  <= w_count_next;
                r_count <= '0;
                r_timer <= '0;
                r_done  <= 1'b1;
`ifdef ALARM_STICKY_EN
                r_alarm <= r_alarm | w_alarm_hit;
`else
                r_alarm <= w_alarm_hit;
`endif
              end else begin
                r_count <= w_count_next;
                r_timer <= r_timer + TMR_W'(1);
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count      = r_count;
  assign bus.last_count = r_last;
  assign bus.win_done   = r_done;
  assign bus.alarm      = r_alarm;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter: two instances (CNT_W=4 and CNT_W=2,
// WIN_LEN=8, THRESH=3) share one stimulus stream. A window-level reference
// model is checked every cycle; a vector table and hand-written sequences
// cover the documented corner cases; a random phase follows.
module tb_match_window_counter;
  localparam int WIN = 8;
  localparam int TH  = 3;
`ifdef ALARM_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, hold = 1'b0, stop = 1'b0, z = 1'b0;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  always #5 clk = ~clk;

  match_window_counter_if #(.CNT_W(4)) if_a ();
  match_window_counter_if #(.CNT_W(2)) if_b ();

  assign if_a.z_in  = z;
  assign if_a.start = start;
  assign if_a.hold  = hold;
  assign if_a.stop  = stop;
  assign if_b.z_in  = z;
  assign if_b.start = start;
  assign if_b.hold  = hold;
  assign if_b.stop  = stop;

  match_window_counter #(.CNT_W(4), .WIN_LEN(WIN), .THRESH(TH)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  match_window_counter #(.CNT_W(2), .WIN_LEN(WIN), .THRESH(TH)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  // Reference model: a window is "elapsed running cycles" plus an unbounded
  // match tally; saturation is applied only when the tally is reported.
  int m_matches[2];
  int m_elapsed[2];
  int m_last[2];
  bit m_active[2];
  bit m_done[2];
  bit m_alarm[2];

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int cap(int k);
    return (k == 0) ? 15 : 3;
  endfunction

  task automatic model_update(bit s, bit h, bit p, bit zz, bit r);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (r) begin
        m_active[k] = 1'b0; m_matches[k] = 0; m_elapsed[k] = 0;
        m_last[k] = 0; m_alarm[k] = 1'b0;
      end else if (p) begin
        m_active[k] = 1'b0; m_matches[k] = 0; m_elapsed[k] = 0;
        if (STICKY) m_alarm[k] = 1'b0;
      end else if (!m_active[k]) begin
        if (s && !h) begin
          m_active[k] = 1'b1; m_matches[k] = 0; m_elapsed[k] = 0;
        end
      end else if (!h) begin
        m_matches[k] += int'(zz);
        m_elapsed[k]++;
        if (m_elapsed[k] == WIN) begin
          m_last[k]    = imin(m_matches[k], cap(k));
          m_alarm[k]   = (m_last[k] >= TH) || (STICKY && m_alarm[k]);
          m_done[k]    = 1'b1;
          m_matches[k] = 0;
          m_elapsed[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // One clock of stimulus, then every output of both instances vs the model
  task automatic step(bit s, bit h, bit p, bit zz, bit r, string tag);
    start = s; hold = h; stop = p; z = zz; reset = r;
    @(posedge clk);
    model_update(s, h, p, zz, r);
    #1;
    ncyc++;
    chk({tag, ".a.count"}, 32'(if_a.count),      32'(imin(m_matches[0], cap(0))));
    chk({tag, ".a.last"},  32'(if_a.last_count), 32'(m_last[0]));
    chk({tag, ".a.done"},  32'(if_a.win_done),   32'(m_done[0]));
    chk({tag, ".a.alarm"}, 32'(if_a.alarm),      32'(m_alarm[0]));
    chk({tag, ".a.busy"},  32'(if_a.busy),       32'(m_active[0]));
    chk({tag, ".b.count"}, 32'(if_b.count),      32'(imin(m_matches[1], cap(1))));
    chk({tag, ".b.last"},  32'(if_b.last_count), 32'(m_last[1]));
    chk({tag, ".b.done"},  32'(if_b.win_done),   32'(m_done[1]));
    chk({tag, ".b.alarm"}, 32'(if_b.alarm),      32'(m_alarm[1]));
    chk({tag, ".b.busy"},  32'(if_b.busy),       32'(m_active[1]));
    $display("cyc=%0d %s in s=%0b h=%0b p=%0b z=%0b r=%0b | a cnt=%0d last=%0d wd=%0b al=%0b busy=%0b | b cnt=%0d last=%0d",
             ncyc, tag, s, h, p, zz, r, if_a.count, if_a.last_count, if_a.win_done,
             if_a.alarm, if_a.busy, if_b.count, if_b.last_count);
  endtask

  task automatic run_n(int n, bit zz, string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, zz, 1'b0, tag);
  endtask

  // Runs with z_in low until win_done; n = cycles taken, ok = seen in bound
  task automatic wait_done(int bound, string tag, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < bound) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
      n++;
      if (if_a.win_done === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s.timeout actual=no_win_done required=win_done within %0d", tag, bound);
    end
  endtask

  typedef struct {
    bit s, h, p, zz, r;
    int cnt, last;
    bit wd, al, busy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n;
    bit ok;
    bit al_stop;
    for (int k = 0; k < 2; k++) begin
      m_matches[k] = 0; m_elapsed[k] = 0; m_last[k] = 0;
      m_active[k] = 1'b0; m_done[k] = 1'b0; m_alarm[k] = 1'b0;
    end
    al_stop = !STICKY;

    // Start, matches on window cycles 2/5/8, then start-ignored, stop, start+stop
    tbl[0]  = '{s:0, h:0, p:0, zz:0, r:1, cnt:0, last:0, wd:0, al:0, busy:0};
    tbl[1]  = '{s:1, h:0, p:0, zz:1, r:0, cnt:0, last:0, wd:0, al:0, busy:1};
    tbl[2]  = '{s:0, h:0, p:0, zz:0, r:0, cnt:0, last:0, wd:0, al:0, busy:1};
    tbl[3]  = '{s:0, h:0, p:0, zz:1, r:0, cnt:1, last:0, wd:0, al:0, busy:1};
    tbl[4]  = '{s:0, h:0, p:0, zz:0, r:0, cnt:1, last:0, wd:0, al:0, busy:1};
    tbl[5]  = '{s:0, h:0, p:0, zz:0, r:0, cnt:1, last:0, wd:0, al:0, busy:1};
    tbl[6]  = '{s:0, h:0, p:0, zz:1, r:0, cnt:2, last:0, wd:0, al:0, busy:1};
    tbl[7]  = '{s:0, h:0, p:0, zz:0, r:0, cnt:2, last:0, wd:0, al:0, busy:1};
    tbl[8]  = '{s:0, h:0, p:0, zz:0, r:0, cnt:2, last:0, wd:0, al:0, busy:1};
    tbl[9]  = '{s:0, h:0, p:0, zz:1, r:0, cnt:0, last:3, wd:1, al:1, busy:1};
    tbl[10] = '{s:1, h:0, p:0, zz:0, r:0, cnt:0, last:3, wd:0, al:1, busy:1};
    tbl[11] = '{s:0, h:0, p:0, zz:1, r:0, cnt:1, last:3, wd:0, al:1, busy:1};
    tbl[12] = '{s:0, h:0, p:1, zz:0, r:0, cnt:0, last:3, wd:0, al:al_stop, busy:0};
    tbl[13] = '{s:1, h:0, p:1, zz:0, r:0, cnt:0, last:3, wd:0, al:al_stop, busy:0};
    tbl[14] = '{s:1, h:0, p:0, zz:0, r:0, cnt:0, last:3, wd:0, al:al_stop, busy:1};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].h, tbl[i].p, tbl[i].zz, tbl[i].r, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.count", i), 32'(if_a.count),      32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.last", i),  32'(if_a.last_count), 32'(tbl[i].last));
      chk($sformatf("tbl%0d.done", i),  32'(if_a.win_done),   32'(tbl[i].wd));
      chk($sformatf("tbl%0d.alarm", i), 32'(if_a.alarm),      32'(tbl[i].al));
      chk($sformatf("tbl%0d.busy", i),  32'(if_a.busy),       32'(tbl[i].busy));
    end

    // Matches on the last cycle of one window and the first of the next
    step(0, 0, 0, 0, 1, "bb");
    step(1, 0, 0, 0, 0, "bb");
    run_n(7, 1'b0, "bb");
    step(0, 0, 0, 1, 0, "bb");
    chk("bb.done1", 32'(if_a.win_done), 32'd1);
    chk("bb.last1", 32'(if_a.last_count), 32'd1);
    step(0, 0, 0, 1, 0, "bb");
    chk("bb.newcount", 32'(if_a.count), 32'd1);
    wait_done(20, "bb", n, ok);
    if (ok) chk("bb.spacing", 32'(n + 1), 32'd8);
    chk("bb.last2", 32'(if_a.last_count), 32'd1);

    // Hold for 4 cycles with z_in high throughout: ignored, window delayed by 4
    step(0, 0, 0, 0, 1, "hold");
    step(1, 0, 0, 0, 0, "hold");
    run_n(3, 1'b0, "hold");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1, 0, "hold");
      chk("hold.count", 32'(if_a.count), 32'd0);
      chk("hold.busy", 32'(if_a.busy), 32'd1);
    end
    wait_done(20, "hold", n, ok);
    if (ok) chk("hold.delay", 32'(3 + 4 + n), 32'd12);
    chk("hold.last", 32'(if_a.last_count), 32'd0);

    // Saturation with a 2-bit counter while z_in stays high for a window
    step(0, 0, 0, 0, 1, "sat");
    step(1, 0, 0, 0, 0, "sat");
    run_n(4, 1'b1, "sat");
    chk("sat.b.count", 32'(if_b.count), 32'd3);
    run_n(4, 1'b1, "sat");
    chk("sat.b.last", 32'(if_b.last_count), 32'd3);
    chk("sat.a.last", 32'(if_a.last_count), 32'd8);

    // Reset mid-window, then stop mid-window
    step(0, 0, 0, 0, 1, "rst");
    step(1, 0, 0, 0, 0, "rst");
    run_n(3, 1'b1, "rst");
    run_n(5, 1'b0, "rst");
    run_n(3, 1'b1, "rst");
    step(0, 0, 0, 1, 1, "rst");
    chk("rst.count", 32'(if_a.count), 32'd0);
    chk("rst.last", 32'(if_a.last_count), 32'd0);
    chk("rst.alarm", 32'(if_a.alarm), 32'd0);
    chk("rst.busy", 32'(if_a.busy), 32'd0);
    step(1, 0, 0, 0, 0, "stp");
    run_n(3, 1'b1, "stp");
    run_n(5, 1'b0, "stp");
    run_n(3, 1'b1, "stp");
    step(0, 0, 1, 1, 0, "stp");
    chk("stp.busy", 32'(if_a.busy), 32'd0);
    chk("stp.count", 32'(if_a.count), 32'd0);
    chk("stp.last", 32'(if_a.last_count), 32'd3);
    chk("stp.alarm", 32'(if_a.alarm), 32'(!STICKY));
    chk("stp.done", 32'(if_a.win_done), 32'd0);

    // Window with 3 matches followed by an empty window
    step(0, 0, 0, 0, 1, "alm");
    step(1, 0, 0, 0, 0, "alm");
    run_n(3, 1'b1, "alm");
    run_n(5, 1'b0, "alm");
    chk("alm.first", 32'(if_a.alarm), 32'd1);
    run_n(8, 1'b0, "alm");
    chk("alm.done2", 32'(if_a.win_done), 32'd1);
    chk("alm.second", 32'(if_a.alarm), 32'(STICKY));
    chk("alm.last2", 32'(if_a.last_count), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(99) < 20), ($urandom_range(99) < 15),
           ($urandom_range(99) < 4), ($urandom_range(99) < 45),
           ($urandom_range(99) < 1), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/match_window_counter.md
MATCH_WINDOW_COUNTER -- requirements
Module: match_window_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the match counters.
REQ-002 SHALL have parameter WIN_LEN, default 16: window length in counted cycles; legal range 2..65535.
REQ-003 SHALL have parameter THRESH, default 3: alarm threshold; legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port z_in, input, 1: match pulse from the upstream sequence detector, one cycle per match.
REQ-007 SHALL have port start, input, 1: begin windowed counting from IDLE.
REQ-008 SHALL have port hold, input, 1: freeze the window while high.
REQ-009 SHALL have port stop, input, 1: abort counting and return to IDLE.
REQ-010 SHALL have port count, output, CNT_W: live match count of the current window.
REQ-011 SHALL have port last_count, output, CNT_W: final count of the most recently completed window.
REQ-012 SHALL have port win_done, output, 1: one-cycle pulse after each window completes.
REQ-013 SHALL have port alarm, output, 1: last completed window count >= THRESH.
REQ-014 SHALL have port busy, output, 1: high when the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and HOLD; all outputs registered.
REQ-016 Per-cycle priority SHALL be: reset > stop > hold > start/window logic.
REQ-017 IDLE: start=1 -> RUN; timer and count cleared to 0; z_in ignored.
REQ-018 RUN: each cycle timer +1; z_in=1 -> count +1.
REQ-019 count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 RUN with timer==WIN_LEN-1: last_count <= saturated count+z_in; count <= 0; timer <= 0; win_done=1 next cycle; alarm updated; state stays RUN (back-to-back windows, no dead cycle).
REQ-021 hold=1 in RUN -> HOLD: that cycle is not counted; timer and count frozen; z_in ignored.
REQ-022 HOLD: z_in ignored; hold=0 -> RUN, counting resumes on that cycle.
REQ-023 hold=1 on a window-end cycle: hold wins; window end deferred until resume.
REQ-024 stop=1 in any state -> IDLE: count and timer cleared; last_count and alarm retained; no win_done.
REQ-025 start=1 in RUN or HOLD SHALL be ignored; start=1 with stop=1 in IDLE -> stays IDLE.
REQ-026 Timer width SHALL be $clog2(WIN_LEN).

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE; count, last_count, timer, win_done, alarm and busy all 0; effective mid-window with no report.
REQ-028 No asynchronous behaviour; the reset input is sampled only on clk.

Configuration
REQ-029 Macro ALARM_STICKY_EN defined: alarm, once set, stays 1 until stop or reset.
REQ-030 Macro ALARM_STICKY_EN undefined: alarm is recomputed at every window end from the new last_count only.

Verification (CNT_W=4, WIN_LEN=8, THRESH=3 unless stated)
REQ-031 start at edge 0; z_in=1 on window cycles 2, 5, 8 -> win_done high exactly cycle 9; last_count=3; alarm=1; count=0 in cycle 9.
REQ-032 z_in=1 on the final window cycle and on the first cycle of the next window -> counted in the ending and the new window respectively; consecutive win_done pulses 8 cycles apart.
REQ-033 hold high for 4 cycles mid-window with z_in=1 throughout the hold -> matches ignored; win_done delayed by exactly 4 cycles.
REQ-034 CNT_W=2, z_in held 1 for a full window -> count sticks at 3; last_count=3.
REQ-035 reset in cycle 4 of a window -> next cycle all outputs 0, busy=0; stop instead -> busy=0, count=0, last_count and alarm unchanged.
REQ-036 Window with 3 matches, then window with 0 matches -> alarm stays 1 with ALARM_STICKY_EN; alarm falls to 0 at the second win_done without it.
